// File: rtl/vel_ctrl_pkg.sv
// vel_ctrl_pkg: shared state encoding and fixed RAM slot constants
// for the per-cell velocity read sequencer.
package vel_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CNT,
        S_CNT_WAIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } vel_state_e;

    // RAM word 0 of every cell holds the particle count.
    localparam int unsigned CNT_SLOT = 0;

endpackage

// File: rtl/velocity_cell_ctrl.sv
// velocity_cell_ctrl: streams one cell's particle velocities and shares the RAM port
// with write-back (write wins). Optional count clamp: VEL_CTRL_CNT_CLAMP_EN.
module velocity_cell_ctrl
    import vel_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_id,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_grant,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    vel_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_id_q, rd_id_d;
    logic [ADDR_WIDTH-1:0] cnt_in;

`ifdef VEL_CTRL_CNT_CLAMP_EN
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    // Count word from RAM, limited so the stream never reads past RAM depth.
    always_comb begin
        cnt_in = mem_q[ADDR_WIDTH-1:0];
        if (cnt_in > CNT_MAX) begin
            cnt_in = CNT_MAX;
        end
    end
`else
    // Count word from RAM, used as-is.
    always_comb begin
        cnt_in = mem_q[ADDR_WIDTH-1:0];
    end
`endif

    // Sequencer state, counters and read tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Next state plus RAM port mux; a write request always owns the port.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rd_valid_d  = 1'b0;
        rd_id_d     = rd_id_q;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;

        if (wr_req) begin
            mem_wren    = 1'b1;
            mem_address = wr_addr;
            mem_data    = wr_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_CNT;
                end
            end
            S_RD_CNT: begin
                if (!wr_req) begin
                    mem_rden    = 1'b1;
                    mem_address = ADDR_WIDTH'(CNT_SLOT);
                    state_d     = S_CNT_WAIT;
                end
            end
            S_CNT_WAIT: begin
                cnt_d   = cnt_in;
                ptr_d   = ADDR_WIDTH'(1);
                state_d = (cnt_in == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (!wr_req) begin
                    mem_rden    = 1'b1;
                    mem_address = ptr_q;
                    ptr_d       = ptr_q + ADDR_WIDTH'(1);
                    rd_valid_d  = 1'b1;
                    rd_id_d     = ptr_q;
                    if (ptr_q == cnt_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = mem_q;
    assign wr_grant = wr_req;

endmodule

// File: tb/tb_velocity_cell_ctrl.sv
// tb_velocity_cell_ctrl: scoreboard bench for velocity_cell_ctrl with a RAM model
// and a slot-based reference of the stream timeline.
module tb_velocity_cell_ctrl;

    localparam int DW   = 96;
    localparam int PN   = 220;
    localparam int AW   = 8;
    localparam int MAXC = 1024;

`ifdef VEL_CTRL_CNT_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [AW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_id;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_grant;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    velocity_cell_ctrl #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_id      (rd_id),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_grant   (wr_grant),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one-cycle registered read.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    logic [DW-1:0] shadow [256];
    logic [DW-1:0] snap   [256];
    bit            wq [MAXC];
    logic [AW-1:0] wa [MAXC];
    logic [DW-1:0] wd [MAXC];
    bit            sq [MAXC];

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   drain_cyc = -1;
    logic bexp;

    // Monitor: per-cycle port checks and scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        bexp = !rst && cyc >= busy_lo && cyc <= busy_hi;
        vectors++;
        if (busy !== bexp) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, bexp);
        end
        vectors++;
        if (wr_grant !== wr_req) begin
            errors++;
            $display("FAIL wr_grant cyc=%0d got=%b exp=%b", cyc, wr_grant, wr_req);
        end
        if (wr_req === 1'b1) begin
            vectors++;
            if (mem_wren !== 1'b1 || mem_rden !== 1'b0 ||
                mem_address !== wr_addr || mem_data !== wr_data) begin
                errors++;
                $display("FAIL wr_port cyc=%0d wren=%b rden=%b addr=%0d exp_addr=%0d data=%h exp=%h",
                         cyc, mem_wren, mem_rden, mem_address, wr_addr, mem_data, wr_data);
            end
        end else if (!bexp) begin
            vectors++;
            if (mem_rden !== 1'b0 || mem_wren !== 1'b0 ||
                mem_address !== '0 || mem_data !== '0) begin
                errors++;
                $display("FAIL idle_port cyc=%0d rden=%b wren=%b addr=%0d data=%h exp=all-zero",
                         cyc, mem_rden, mem_wren, mem_address, mem_data);
            end
        end
        if (rst === 1'b1) begin
            vectors++;
            if (done !== 1'b0 || rd_valid !== 1'b0 || rd_id !== '0) begin
                errors++;
                $display("FAIL reset_out cyc=%0d done=%b rd_valid=%b rd_id=%0d exp=0",
                         cyc, done, rd_valid, rd_id);
            end
        end
        if (rd_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected cyc=%0d id=%0d exp=nothing", cyc, rd_id);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done || e.cyc != cyc || rd_id !== e.id || rd_data !== e.data) begin
                    errors++;
                    $display("FAIL rd cyc=%0d id=%0d data=%h exp: cyc=%0d done=%b id=%0d data=%h",
                             cyc, rd_id, rd_data, e.cyc, e.is_done, e.id, e.data);
                end
            end
        end
        if (done === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d exp=nothing", cyc);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_done || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL done cyc=%0d exp: cyc=%0d done=%b id=%0d",
                             cyc, e.cyc, e.is_done, e.id);
                end
            end
        end
        if (cyc == drain_cyc) begin
            vectors++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain cyc=%0d left=%0d exp=0 next_cyc=%0d",
                         cyc, exp_q.size(), exp_q[0].cyc);
                exp_q.delete();
            end
        end
    end

    function automatic logic [DW-1:0] pat(input int k);
        return {32'h7A00_0000 + 32'(k), 32'h7B00_0000 + 32'(k), 32'h7C00_0000 + 32'(k)};
    endfunction

    // RAM content of address a as seen by a read issued in relative cycle t.
    function automatic logic [DW-1:0] value_at(input int a, input int t);
        for (int i = t - 1; i >= 0; i--) begin
            if (wq[i] && int'(wa[i]) == a) return wd[i];
        end
        return snap[a];
    endfunction

    task automatic clear_sched();
        for (int r = 0; r < MAXC; r++) begin
            wq[r] = 1'b0;
            sq[r] = 1'b0;
            wa[r] = '0;
            wd[r] = '0;
        end
    endtask

    task automatic gen_sched();
        for (int r = 0; r < MAXC; r++) begin
            wq[r] = (r < 200) && ($urandom_range(0, 3) == 0);
            sq[r] = 1'b0;
            wa[r] = AW'($urandom_range(0, 24));
            wd[r] = {$urandom, $urandom, $urandom};
            if (wa[r] == '0) wd[r][AW-1:0] = AW'($urandom_range(0, 12));
        end
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        start   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        shadow[a] = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start   = 1'b0;
            wr_req  = 1'b0;
            wr_addr = AW'($urandom);
            wr_data = {$urandom, $urandom, $urandom};
        end
    endtask

    // One stream: model its timeline from free port slots, push expectations, drive it.
    task automatic run_scn(input int rst_rel, input bit busy_starts);
        int c, t, n, done_rel, s0, last;
        logic [DW-1:0] w;
        exp_t e;
        for (int i = 0; i < 256; i++) snap[i] = shadow[i];
        @(posedge clk); #1;
        s0 = cyc;
        t = 1;
        while (wq[t]) t++;
        c = t;
        w = value_at(0, c);
        n = int'(w[AW-1:0]);
        if (CLAMP && n > PN - 1) n = PN - 1;
        if (n == 0) begin
            done_rel = c + 2;
        end else begin
            t = c + 2;
            for (int k = 1; k <= n; k++) begin
                while (wq[t]) t++;
                e.cyc = s0 + t + 1;
                e.is_done = 1'b0;
                e.id = AW'(k);
                e.data = value_at(k, t);
                if (rst_rel < 0 || t + 1 < rst_rel) exp_q.push_back(e);
                t++;
            end
            done_rel = t + 1;
        end
        for (int r = done_rel + 1; r < MAXC; r++) begin
            wq[r] = 1'b0;
            sq[r] = 1'b0;
        end
        if (busy_starts) begin
            for (int r = 1; r <= done_rel; r++) sq[r] = ($urandom_range(0, 2) == 0);
        end
        if (rst_rel < 0) begin
            e.cyc = s0 + done_rel;
            e.is_done = 1'b1;
            e.id = '0;
            e.data = '0;
            exp_q.push_back(e);
            busy_hi = s0 + done_rel;
            last = done_rel + 2;
        end else begin
            busy_hi = s0 + rst_rel - 1;
            last = rst_rel + 2;
        end
        busy_lo = s0 + 1;
        for (int r = 0; r <= last; r++) begin
            if (r > 0) begin
                @(posedge clk); #1;
            end
            start = (r == 0) || sq[r];
            rst = (rst_rel >= 0) && (r == rst_rel || r == rst_rel + 1);
            if (wq[r]) begin
                wr_req  = 1'b1;
                wr_addr = wa[r];
                wr_data = wd[r];
                shadow[wa[r]] = wd[r];
            end else begin
                wr_req  = 1'b0;
                wr_addr = AW'($urandom);
                wr_data = {$urandom, $urandom, $urandom};
            end
        end
        drain_cyc = cyc;
        @(posedge clk); #1;
        start  = 1'b0;
        rst    = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        load(0, 96'd5);
        for (int k = 1; k <= 5; k++) load(k, pat(k));
        idle(2);
        clear_sched();
        run_scn(-1, 1'b0);

        idle(2);
        load(0, 96'd0);
        idle(1);
        clear_sched();
        run_scn(-1, 1'b0);

        idle(2);
        load(0, 96'd5);
        idle(1);
        clear_sched();
        for (int r = 5; r <= 6; r++) begin
            wq[r] = 1'b1;
            wa[r] = AW'(3);
            wd[r] = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
        end
        run_scn(-1, 1'b0);

        idle(2);
        clear_sched();
        run_scn(-1, 1'b1);

        idle(2);
        clear_sched();
        run_scn(6, 1'b0);
        idle(2);
        clear_sched();
        run_scn(-1, 1'b0);

        idle(2);
        load(0, 96'd250);
        for (int k = 1; k <= 250; k++) load(k, pat(k));
        idle(1);
        clear_sched();
        run_scn(-1, 1'b0);

        repeat (40) begin
            idle(2);
            n = $urandom_range(0, 15);
            w = {$urandom, $urandom, $urandom};
            w[AW-1:0] = AW'(n);
            load(0, w);
            for (int k = 1; k <= 20; k++) load(k, {$urandom, $urandom, $urandom});
            idle(1);
            gen_sched();
            run_scn(-1, 1'($urandom_range(0, 1)));
        end

        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/velocity_cell_ctrl.md
# velocity_cell_ctrl

Sequencer and port arbiter for one per-cell velocity RAM (single-port, 1-cycle registered read, address 0 = particle count, addresses 1..N = {vz, vy, vx}). On `start` it reads the count, then streams every particle velocity of the cell to the motion-update or readout consumer. It also shares the single RAM port with a write-back requester, and write-back always takes priority. It sits between the velocity cache logic and the `velocity_x_y_z` memory instance of one cell.

## Interface
- `DATA_WIDTH`, 96, velocity word {vz, vy, vx}, 32 bits each
- `PARTICLE_NUM`, 220, RAM depth including count word; max particles = PARTICLE_NUM-1
- `ADDR_WIDTH`, 8, RAM address width
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin streaming the cell; ignored while `busy`
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse at end of stream
- `rd_valid`  out  1  `rd_data` holds a particle velocity
- `rd_data`  out  DATA_WIDTH  velocity word, passed through from `mem_q`
- `rd_id`  out  ADDR_WIDTH  particle address (1..N) of `rd_data`
- `wr_req`  in  1  write-back request
- `wr_addr`  in  ADDR_WIDTH  write-back address
- `wr_data`  in  DATA_WIDTH  write-back data
- `wr_grant`  out  1  combinational; high = write performed this cycle
- `mem_address`  out  ADDR_WIDTH  to RAM
- `mem_data`  out  DATA_WIDTH  to RAM
- `mem_rden`  out  1  to RAM
- `mem_wren`  out  1  to RAM
- `mem_q`  in  DATA_WIDTH  from RAM, valid 1 cycle after `mem_rden`

## Operation
- States and transitions:
  - IDLE: `start` → RD_CNT.
  - RD_CNT: issues read of address 0; → CNT_WAIT once issued.
  - CNT_WAIT: latches `cnt` = `mem_q[ADDR_WIDTH-1:0]`, with `ptr` = 1; `cnt` == 0 → DONE, else → STREAM.
  - STREAM: issues read of `ptr` and increments `ptr`; after issuing `ptr` == `cnt` → DRAIN.
  - DRAIN: one cycle for the last data → DONE.
  - DONE: `done` = 1 → IDLE.
- Arbitration:
  - `wr_grant` = `wr_req`, in every state.
  - A granted cycle drives `mem_wren` = 1, `mem_rden` = 0, `wr_addr`/`wr_data`.
  - In RD_CNT and STREAM, a granted cycle stalls the read issue: `ptr` and the state are held.
  - In CNT_WAIT, DRAIN and DONE, writes do not disturb the sequence.
- Read tracking:
  - `rd_valid` is a register set the cycle after a particle read issue; address-0 reads never assert it.
  - `rd_id` is the registered issued `ptr`.
- Idle port: `mem_rden` = `mem_wren` = 0, `mem_address` = 0, `mem_data` = 0.
- A write to address 0 during streaming does not change the latched `cnt`.
- `start` together with `wr_req`: the write is granted and the state moves to RD_CNT, which waits for a free cycle.
- Reset (including mid-stream): state = IDLE, `cnt` = `ptr` = 0; `busy`, `done`, `rd_valid`, `rd_id` = 0; any in-flight read is discarded.

## Timing
- `start` high in cycle 0, no writes, count N ≥ 1:
  - cycle 1: read of address 0
  - cycle 2: count latched
  - cycles 3..N+2: reads of addresses 1..N
  - cycles 4..N+3: `rd_valid`
  - cycle N+4: `done`
- `busy` is high in cycles 1..N+4.
- N = 0: `done` in cycle 3, no `rd_valid`.
- Each granted write during RD_CNT or STREAM delays all later events by exactly one cycle.
- Read latency from issue to `rd_valid` is 1 cycle.

## Configuration
- `VEL_CTRL_CNT_CLAMP_EN`:
  - Defined: the latched count is clamped to PARTICLE_NUM-1, so no read goes past RAM depth.
  - Undefined: the raw truncated count is used, with no bounds check.

## Structure
- Shared package `vel_ctrl_pkg`: state encoding (IDLE, RD_CNT, CNT_WAIT, STREAM, DRAIN, DONE) and the address-0 count-slot constant.
- No sub-module: the RAM is instantiated by the parent, and the FSM, arbiter and counters stay in this one module.

## Test plan
- Count = 5, particles 1..5 = 0x..01..0x..05, `start` cycle 0:
  - `rd_valid` cycles 4..8, `rd_id` 1..5 with matching data
  - `done` cycle 9
- Count = 0: `done` cycle 3, `rd_valid` never high, `busy` cycles 1..3.
- Count = 5 with `wr_req` held cycles 5–6 to address 3:
  - `wr_grant` in both cycles
  - stream shifted 2 cycles, `done` cycle 11
  - particle 3 read returns the written value
- `start` pulses during `busy`: ignored, exactly one `done`.
- `rst` asserted in cycle 6 of a count = 5 stream:
  - all outputs 0 next cycle
  - a new `start` replays the full stream correctly
- Count word = 250:
  - with `VEL_CTRL_CNT_CLAMP_EN`: last `rd_id` = 219
  - without: last `rd_id` = 250
